// File: rtl/mem_ref_pkg.sv
// rtl/mem_ref_pkg.sv - shared widths, state encoding and op indices for the memory-reference execute stage
package mem_ref_pkg;

  localparam int DEF_ADDR_W = 12;
  localparam int DEF_DATA_W = 16;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    IND_RD = 3'd1,
    RD     = 3'd2,
    WR     = 3'd3,
    DONE   = 3'd4
  } state_t;

  // Bit positions of the op strobes as exchanged with the control unit
  localparam int OP_ADD  = 0;
  localparam int OP_LDA  = 1;
  localparam int OP_STA  = 2;
  localparam int OP_BUN  = 3;
  localparam int OP_ISZ  = 4;
  localparam int NUM_OPS = 5;

  // Reduce a possibly multi-hot op vector to one-hot; lowest index wins
  function automatic logic [NUM_OPS-1:0] pick_op(input logic [NUM_OPS-1:0] ops);
    pick_op = '0;
    for (int i = NUM_OPS - 1; i >= 0; i--) begin
      if (ops[i]) begin
        pick_op    = '0;
        pick_op[i] = 1'b1;
      end
    end
  endfunction

endpackage

// File: rtl/mem_ref_exec.sv
// rtl/mem_ref_exec.sv - execute stage for ADD/LDA/STA/BUN/ISZ with direct or indirect addressing
module mem_ref_exec
  import mem_ref_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              i_start,
  input  logic              i_ind,
  input  logic              i_add,
  input  logic              i_load,
  input  logic              i_store,
  input  logic              i_branch,
  input  logic              i_isz,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_ac,
  output logic              o_mem_req,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_wdata,
  input  logic [DATA_W-1:0] i_mem_rdata,
  input  logic              i_mem_ack,
  output logic              o_ac_we,
  output logic [DATA_W-1:0] o_ac_wdata,
  output logic              o_e_we,
  output logic              o_e_wdata,
  output logic              o_pc_load,
  output logic [ADDR_W-1:0] o_pc_wdata,
  output logic              o_pc_inc,
  output logic              o_busy,
  output logic              o_ex_done
);

  state_t               state, state_n;
  logic [NUM_OPS-1:0]   op_q;
  logic [NUM_OPS-1:0]   op_start;
  logic [ADDR_W-1:0]    ea;
  logic [DATA_W-1:0]    ac_q;
  logic [DATA_W-1:0]    mdata;
  logic [DATA_W:0]      add_sum;
  logic [DATA_W:0]      inc_sum;

  assign op_start = pick_op({i_isz, i_branch, i_store, i_load, i_add});
  assign add_sum  = {1'b0, ac_q} + {1'b0, mdata};
  assign inc_sum  = {1'b0, mdata} + {{DATA_W{1'b0}}, 1'b1};

  // Once the effective address is known: BUN needs no data, STA only writes
  function automatic state_t addr_next(input logic [NUM_OPS-1:0] op);
    if (op[OP_BUN])      return DONE;
    else if (op[OP_STA]) return WR;
    else                 return RD;
  endfunction

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      op_q  <= '0;
      ea    <= '0;
      ac_q  <= '0;
      mdata <= '0;
    end else begin
      state <= state_n;
      if (state == IDLE && i_start) begin
        op_q <= op_start;
        ea   <= i_addr;
        ac_q <= i_ac;
      end
      if (state == IND_RD && i_mem_ack) ea <= i_mem_rdata[ADDR_W-1:0];
      if (state == RD && i_mem_ack) mdata <= i_mem_rdata;
    end
  end

  always_comb begin
    state_n     = state;
    o_mem_req   = 1'b0;
    o_mem_we    = 1'b0;
    o_mem_addr  = '0;
    o_mem_wdata = '0;
    o_ac_we     = 1'b0;
    o_ac_wdata  = '0;
    o_e_we      = 1'b0;
    o_e_wdata   = 1'b0;
    o_pc_load   = 1'b0;
    o_pc_wdata  = '0;
    o_pc_inc    = 1'b0;
    o_ex_done   = 1'b0;
    o_busy      = (state != IDLE);
    case (state)
      IDLE: begin
        if (i_start) begin
          if (op_start == '0) state_n = DONE;
          else if (i_ind)     state_n = IND_RD;
          else                state_n = addr_next(op_start);
        end
      end
      IND_RD: begin
        o_mem_req  = 1'b1;
        o_mem_addr = ea;
        if (i_mem_ack) state_n = addr_next(op_q);
      end
      RD: begin
        o_mem_req  = 1'b1;
        o_mem_addr = ea;
        if (i_mem_ack) state_n = op_q[OP_ISZ] ? WR : DONE;
      end
      WR: begin
        o_mem_req   = 1'b1;
        o_mem_we    = 1'b1;
        o_mem_addr  = ea;
        o_mem_wdata = op_q[OP_STA] ? ac_q : inc_sum[DATA_W-1:0];
        if (i_mem_ack) state_n = DONE;
      end
      DONE: begin
        o_ex_done = 1'b1;
        if (op_q[OP_ADD]) begin
          o_ac_we    = 1'b1;
          o_ac_wdata = add_sum[DATA_W-1:0];
          o_e_we     = 1'b1;
          o_e_wdata  = add_sum[DATA_W];
        end
        if (op_q[OP_LDA]) begin
          o_ac_we    = 1'b1;
          o_ac_wdata = mdata;
        end
        if (op_q[OP_BUN]) begin
          o_pc_load  = 1'b1;
          o_pc_wdata = ea;
        end
        // Skip when the incremented word wrapped to zero
        o_pc_inc = op_q[OP_ISZ] & inc_sum[DATA_W];
        state_n  = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mem_ref_exec.sv
// tb/tb_mem_ref_exec.sv - scoreboard bench for mem_ref_exec with a random-wait memory responder
module tb_mem_ref_exec;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        i_start, i_ind, i_add, i_load, i_store, i_branch, i_isz;
  logic [11:0] i_addr;
  logic [15:0] i_ac;
  logic        o_mem_req, o_mem_we;
  logic [11:0] o_mem_addr;
  logic [15:0] o_mem_wdata;
  logic [15:0] i_mem_rdata;
  logic        i_mem_ack;
  logic        o_ac_we;
  logic [15:0] o_ac_wdata;
  logic        o_e_we, o_e_wdata, o_pc_load;
  logic [11:0] o_pc_wdata;
  logic        o_pc_inc, o_busy, o_ex_done;

  mem_ref_exec dut (
    .clk(clk), .reset_n(reset_n), .i_start(i_start), .i_ind(i_ind),
    .i_add(i_add), .i_load(i_load), .i_store(i_store), .i_branch(i_branch), .i_isz(i_isz),
    .i_addr(i_addr), .i_ac(i_ac),
    .o_mem_req(o_mem_req), .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr),
    .o_mem_wdata(o_mem_wdata), .i_mem_rdata(i_mem_rdata), .i_mem_ack(i_mem_ack),
    .o_ac_we(o_ac_we), .o_ac_wdata(o_ac_wdata), .o_e_we(o_e_we), .o_e_wdata(o_e_wdata),
    .o_pc_load(o_pc_load), .o_pc_wdata(o_pc_wdata), .o_pc_inc(o_pc_inc),
    .o_busy(o_busy), .o_ex_done(o_ex_done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        ac_we;
    logic [15:0] ac_wdata;
    logic        e_we;
    logic        e_wdata;
    logic        pc_load;
    logic [11:0] pc_wdata;
    logic        pc_inc;
  } eff_t;

  typedef struct packed {
    logic        we;
    logic [11:0] addr;
    logic [15:0] wdata;
  } xfer_t;

  localparam logic [4:0] ADD = 5'b00001, LDA = 5'b00010, STA = 5'b00100,
                         BUN = 5'b01000, ISZ = 5'b10000;

  int    errors = 0, checks = 0;
  int    cyc = 0, start_cyc = 0, waits = 0, force_wait = -1;
  logic [15:0] mem [0:4095];
  eff_t  eff_q[$];
  int    lat_q[$];
  xfer_t xfer_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: walks the instruction at the level of memory words
  task automatic model(input logic [4:0] ops, input logic ind, input logic [11:0] addr,
                       input logic [15:0] ac);
    eff_t e;
    logic [11:0] ea;
    logic [15:0] m, m_inc;
    logic [16:0] s;
    int n;
    e  = '0;
    ea = addr;
    n  = 0;
    if (ops != 5'b0) begin
      if (ind) begin
        xfer_q.push_back({1'b0, addr, 16'h0000}); n++;
        m  = mem[addr];
        ea = m[11:0];
      end
      m = mem[ea];
      if (ops[0]) begin
        xfer_q.push_back({1'b0, ea, 16'h0000}); n++;
        s = {1'b0, ac} + {1'b0, m};
        e.ac_we = 1'b1; e.ac_wdata = s[15:0]; e.e_we = 1'b1; e.e_wdata = s[16];
      end else if (ops[1]) begin
        xfer_q.push_back({1'b0, ea, 16'h0000}); n++;
        e.ac_we = 1'b1; e.ac_wdata = m;
      end else if (ops[2]) begin
        xfer_q.push_back({1'b1, ea, ac}); n++;
      end else if (ops[3]) begin
        e.pc_load = 1'b1; e.pc_wdata = ea;
      end else begin
        m_inc = m + 16'd1;
        xfer_q.push_back({1'b0, ea, 16'h0000});
        xfer_q.push_back({1'b1, ea, m_inc}); n += 2;
        e.pc_inc = (m_inc == 16'h0000);
      end
    end
    eff_q.push_back(e);
    lat_q.push_back(1 + n);
  endtask

  // Memory responder: random ack delay, checks each completed transfer and request stability
  xfer_t hold;
  bit    armed = 0;
  int    wcnt = 0;
  always @(negedge clk) begin
    if (!reset_n) begin
      i_mem_ack = 1'b0;
      armed = 0;
    end else if (o_mem_req) begin
      if (!armed) begin
        armed = 1;
        hold  = {o_mem_we, o_mem_addr, o_mem_wdata};
        if (force_wait >= 0) wcnt = force_wait;
        else wcnt = ($urandom_range(0, 1) == 0) ? 0 : int'($urandom_range(1, 3));
      end else begin
        checks++;
        if ({o_mem_we, o_mem_addr, o_mem_wdata} !== hold) begin
          errors++;
          $display("FAIL req_stable got %h exp %h", {o_mem_we, o_mem_addr, o_mem_wdata}, hold);
        end
      end
      if (wcnt == 0) begin
        i_mem_ack   = 1'b1;
        i_mem_rdata = mem[o_mem_addr];
        armed = 0;
        checks++;
        if (xfer_q.size() == 0) begin
          errors++;
          $display("FAIL xfer_unexpected got %h exp none", {o_mem_we, o_mem_addr, o_mem_wdata});
        end else begin
          xfer_t x;
          x = xfer_q.pop_front();
          if (o_mem_we !== x.we || o_mem_addr !== x.addr || (x.we && o_mem_wdata !== x.wdata)) begin
            errors++;
            $display("FAIL xfer got %h exp %h", {o_mem_we, o_mem_addr, o_mem_wdata}, x);
          end
        end
        if (o_mem_we) mem[o_mem_addr] = o_mem_wdata;
      end else begin
        i_mem_ack = 1'b0;
        wcnt--;
        waits++;
      end
    end else begin
      i_mem_ack   = 1'b0;
      i_mem_rdata = 16'($urandom);
      armed = 0;
    end
  end

  // Completion monitor
  always @(negedge clk) begin
    if (reset_n) begin
      checks++;
      if (o_ex_done) begin
        if (eff_q.size() == 0) begin
          errors++;
          $display("FAIL done_unexpected got done exp none");
        end else begin
          eff_t e, a;
          int l;
          e = eff_q.pop_front();
          l = lat_q.pop_front();
          a = {o_ac_we, o_ac_wdata, o_e_we, o_e_wdata, o_pc_load, o_pc_wdata, o_pc_inc};
          if (a !== e) begin
            errors++;
            $display("FAIL done_effects got %h exp %h", a, e);
          end
          checks++;
          if (cyc - start_cyc != l + waits) begin
            errors++;
            $display("FAIL latency got %0d exp %0d", cyc - start_cyc, l + waits);
          end
        end
      end else if (o_ac_we | o_e_we | o_pc_load | o_pc_inc) begin
        errors++;
        $display("FAIL stray_strobe got %b exp 0000", {o_ac_we, o_e_we, o_pc_load, o_pc_inc});
      end
    end
  end

  task automatic scramble();
    {i_isz, i_branch, i_store, i_load, i_add} = 5'($urandom);
    i_ind  = 1'($urandom);
    i_addr = 12'($urandom);
    i_ac   = 16'($urandom);
  endtask

  task automatic wait_idle();
    int n = 0;
    while (o_busy && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    checks++;
    if (n >= 100) begin
      errors++;
      $display("FAIL idle_timeout got busy exp idle");
    end
    checks++;
    if (eff_q.size() != 0) begin
      errors++;
      $display("FAIL done_missing got %0d pending exp 0", eff_q.size());
      eff_q.delete(); lat_q.delete(); xfer_q.delete();
    end
  endtask

  task automatic issue(input logic [4:0] ops, input logic ind, input logic [11:0] addr,
                       input logic [15:0] ac, input bit poke);
    model(ops, ind, addr, ac);
    @(posedge clk); #1;
    {i_isz, i_branch, i_store, i_load, i_add} = ops;
    i_ind = ind; i_addr = addr; i_ac = ac; i_start = 1'b1;
    start_cyc = cyc;
    waits = 0;
    @(posedge clk); #1;
    i_start = poke;
    scramble();
    if (poke) begin
      @(posedge clk); #1;
      i_start = 1'b0;
    end
    wait_idle();
  endtask

  task automatic check_val(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", name, got, exp);
    end
  endtask

  initial begin
    reset_n = 1'b0;
    i_start = 1'b0;
    i_ind = 1'b0; i_add = 1'b0; i_load = 1'b0; i_store = 1'b0; i_branch = 1'b0; i_isz = 1'b0;
    i_addr = '0; i_ac = '0;
    i_mem_ack = 1'b0; i_mem_rdata = '0;
    for (int i = 0; i < 4096; i++) mem[i] = 16'($urandom);
    repeat (3) @(posedge clk);
    #1;
    check_val("reset_outputs",
              {o_mem_req, o_mem_we, o_mem_addr, o_mem_wdata, o_ac_we, o_ac_wdata, o_e_we,
               o_e_wdata, o_pc_load, o_pc_wdata, o_pc_inc, o_busy, o_ex_done} == '0, 32'd1);
    reset_n = 1'b1;

    force_wait = 0;
    mem[12'h010] = 16'h1234;
    issue(LDA, 1'b0, 12'h010, 16'h7777, 1'b0);
    mem[12'h020] = 16'h0030;
    mem[12'h030] = 16'h0001;
    issue(ADD, 1'b1, 12'h020, 16'hFFFF, 1'b0);
    mem[12'h040] = 16'hFFFF;
    issue(ISZ, 1'b0, 12'h040, 16'h0000, 1'b0);
    check_val("isz_wrap_mem", {16'h0, mem[12'h040]}, 32'h0000);
    mem[12'h040] = 16'h0005;
    issue(ISZ, 1'b0, 12'h040, 16'h0000, 1'b0);
    check_val("isz_inc_mem", {16'h0, mem[12'h040]}, 32'h0006);
    force_wait = 3;
    issue(STA, 1'b0, 12'h0AB, 16'hBEEF, 1'b0);
    check_val("sta_mem", {16'h0, mem[12'h0AB]}, 32'hBEEF);
    force_wait = 0;
    issue(BUN, 1'b0, 12'h155, 16'h0000, 1'b0);
    mem[12'h0C0] = 16'h0321;
    issue(BUN, 1'b1, 12'h0C0, 16'h0000, 1'b1);
    issue(5'b00000, 1'b1, 12'h001, 16'h1111, 1'b0);
    issue(5'b11111, 1'b0, 12'h002, 16'h2222, 1'b0);

    // Reset while an LDA read is waiting on ack
    force_wait = 6;
    model(LDA, 1'b0, 12'h077, 16'h0000);
    @(posedge clk); #1;
    {i_isz, i_branch, i_store, i_load, i_add} = LDA;
    i_ind = 1'b0; i_addr = 12'h077; i_start = 1'b1;
    @(posedge clk); #1;
    i_start = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset_n = 1'b0;
    #1;
    check_val("reset_drops_req", {o_mem_req, o_busy, o_ex_done, o_ac_we}, 32'h0);
    eff_q.delete(); lat_q.delete(); xfer_q.delete();
    @(posedge clk); #1;
    reset_n = 1'b1;
    force_wait = 0;
    mem[12'h077] = 16'h4242;
    issue(LDA, 1'b0, 12'h077, 16'h0000, 1'b0);

    force_wait = -1;
    for (int k = 0; k < 300; k++) begin
      logic [4:0] ops;
      if ($urandom_range(0, 9) < 8) ops = 5'(1 << $urandom_range(0, 4));
      else ops = 5'($urandom);
      issue(ops, 1'($urandom), 12'($urandom), 16'($urandom), 1'b0);
    end

    repeat (3) @(posedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_ref_exec.md
Name: mem_ref_exec

Overview:
- Execute stage for memory-reference instructions: ADD, LDA, STA, BUN, ISZ, each with direct or indirect addressing.
- Consumes the one-hot operation strobes and indirect flag from the control unit.
- Drives a req/ack memory port and the AC/E/PC write strobes.
- Returns a one-cycle o_ex_done pulse that the control unit uses to leave its MEM_REF state. Non-pipelined: one instruction in flight at a time.

Parameters:
ADDR_W, 12, memory address width; effective address is taken from the low ADDR_W bits.
DATA_W, 16, memory word, AC and instruction width.

Ports:
clk  in  1  clock
reset_n  in  1  async active-low reset
i_start  in  1  one-cycle pulse; sample op, ind and addr
i_ind  in  1  indirect addressing
i_add  in  1  op ADD
i_load  in  1  op LDA
i_store  in  1  op STA
i_branch  in  1  op BUN
i_isz  in  1  op ISZ
i_addr  in  ADDR_W  address field of IR
i_ac  in  DATA_W  current AC value
o_mem_req  out  1  memory request, held until ack
o_mem_we  out  1  1=write, 0=read; valid while req
o_mem_addr  out  ADDR_W  memory address
o_mem_wdata  out  DATA_W  memory write data
i_mem_rdata  in  DATA_W  read data, valid in ack cycle
i_mem_ack  in  1  transfer completes on req&ack
o_ac_we  out  1  load AC strobe
o_ac_wdata  out  DATA_W  new AC value
o_e_we  out  1  load E strobe
o_e_wdata  out  1  new E value (ADD carry)
o_pc_load  out  1  PC <= o_pc_wdata
o_pc_wdata  out  ADDR_W  branch target
o_pc_inc  out  1  skip: PC <= PC+1
o_busy  out  1  not IDLE
o_ex_done  out  1  one-cycle completion pulse

Behaviour:
- Reset (async): state IDLE; all outputs 0.
- Clock domain: single clk, all state registered. A transfer completes in any cycle with o_mem_req && i_mem_ack; ack may arrive in the same cycle as req or later.
- While req is high, o_mem_we, o_mem_addr and o_mem_wdata are held stable.
- States:
  - IDLE: on i_start, latch op, i_ind, i_addr and i_ac; ea <= i_addr.
    - ind=1: go to IND_RD.
    - Else BUN: go to DONE.
    - Else STA: go to WR.
    - Else: go to RD.
  - IND_RD: req=1, we=0, addr=ea. On ack, ea <= i_mem_rdata[ADDR_W-1:0]; then go to DONE (BUN), WR (STA), or RD (others).
  - RD: req=1, we=0, addr=ea. On ack, latch mdata <= i_mem_rdata. Next state is WR for ISZ, DONE otherwise.
  - WR: req=1, we=1, addr=ea; wdata = latched AC (STA) or mdata+1 mod 2^DATA_W (ISZ). On ack, go to DONE.
  - DONE, for exactly one cycle:
    - o_ex_done=1.
    - ADD: o_ac_we=1, o_ac_wdata = low DATA_W bits of AC+mdata; o_e_we=1, o_e_wdata = carry out.
    - LDA: o_ac_we=1, o_ac_wdata = mdata.
    - BUN: o_pc_load=1, o_pc_wdata = ea.
    - ISZ: o_pc_inc=1 iff mdata+1 == 0 (i.e. mdata == 16'hFFFF).
    - STA: no register strobe.
    - Then go to IDLE.
- Latency with zero-wait memory, measured in cycles from the i_start cycle to the o_ex_done cycle:
  - BUN direct: 1.
  - LDA/ADD/STA direct: 2.
  - ISZ direct: 3.
  - Indirect: +1 on each of the above.
  - Each wait cycle on ack adds 1.
- Op decoding:
  - Ops are one-hot. If several are set, priority is ADD > LDA > STA > BUN > ISZ.
  - i_start with no op set: go directly to DONE, pulse o_ex_done, no strobes.
- i_start while not IDLE is ignored; there is no queueing.
- Operands (op, addr, AC) are latched at start; changes on the inputs mid-operation have no effect.
- Reset asserted mid-operation: immediate return to IDLE and req drops; no o_ex_done and no partial register write. A memory write already acked stays committed.
- o_busy = (state != IDLE).

Decomposition:
- Shared package mem_ref_pkg holds:
  - ADDR_W and DATA_W defaults;
  - state encoding localparams IDLE, IND_RD, RD, WR, DONE (3 bits);
  - the op index constants shared with the control unit.
- No sub-module. The ADD carry and ISZ increment are inline arithmetic on a DATA_W+1 sum.

Test Plan:
- LDA direct: addr=0x010, M[0x010]=0x1234, zero-wait → req at cycle 1 with we=0 and addr=0x010; cycle 2 has o_ac_we=1, o_ac_wdata=0x1234, o_ex_done=1; idle at cycle 3.
- ADD indirect: M[0x020]=0x0030, M[0x030]=0x0001, AC=0xFFFF → reads at 0x020 then 0x030; AC=0x0000 with o_e_wdata=1, o_e_we=1; done at cycle 3.
- ISZ: M[0x040]=0xFFFF → write 0x0000 to 0x040, o_pc_inc=1. Repeat with M[0x040]=0x0005 → write 0x0006, o_pc_inc=0.
- STA with ack delayed 3 cycles, AC=0xBEEF → req/we/addr/wdata held stable for 4 cycles; single write; o_ex_done 1 cycle after ack; no AC/PC strobes.
- BUN direct, addr=0x155 → o_pc_load=1 and o_pc_wdata=0x155 in the cycle after start; no memory request. Second i_start while busy (indirect BUN) is ignored.
- Reset asserted during RD wait of LDA → req drops asynchronously; no o_ex_done, no o_ac_we. A new LDA after reset completes normally.
